// File: rtl/stream_distributor_pkg.sv
// Shared helper for stream_distributor: cyclic search for the next enabled output.
// Optional build macro used by this slice: STREAM_DISTRIBUTOR_SPILL_EN.
package stream_distributor_pkg;

   // Returns {found, index}: the first set bit of mask at or after start, wrapping within the low n bits.
   function automatic logic [5:0] next_enabled(input logic [31:0] mask,
                                               input logic [4:0]  start,
                                               input int unsigned n);
      logic [5:0]  res;
      int unsigned idx;
      res = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         idx = 32'(start) + i;
         if (idx >= n) begin
            idx = idx - n;
         end
         if ((i < n) && !res[5] && mask[idx[4:0]]) begin
            res = {1'b1, idx[4:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/stream_distributor_slot.sv
// Two-entry spill buffer for one distributor output; only built when STREAM_DISTRIBUTOR_SPILL_EN is defined.
// in_ready depends on occupancy only, so the downstream ready never reaches the upstream ready.
module stream_distributor_slot
#(
   parameter type DATA_T = logic
) (
   input  logic  clk,
   input  logic  rst_n,
   input  DATA_T in_data,
   input  logic  in_valid,
   output logic  in_ready,
   output DATA_T out_data,
   output logic  out_valid,
   input  logic  out_ready
);

   DATA_T      slot_mem [2];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic [1:0] count_next;
   logic       push;
   logic       pop;

   assign in_ready   = (count_reg != 2'd2);
   assign out_valid  = (count_reg != 2'd0);
   assign out_data   = slot_mem[rd_ptr_reg];
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign count_next = count_reg + 2'(push) - 2'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_next;
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         slot_mem[wr_ptr_reg] <= in_data;
      end
   end

endmodule

// File: rtl/stream_distributor.sv
// Round-robin distributor of one valid/ready stream over N_OUP enabled outputs.
// Define STREAM_DISTRIBUTOR_SPILL_EN to put a 2-entry spill slot on every output; otherwise zero latency.
module stream_distributor
   import stream_distributor_pkg::*;
#(
   parameter type         DATA_T = logic,
   parameter int unsigned N_OUP  = 2,
   localparam int unsigned IDX_W = $clog2(N_OUP)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_OUP-1:0] en_i,
   input  DATA_T            inp_data_i,
   input  logic             inp_valid_i,
   output logic             inp_ready_o,
   output DATA_T            oup_data_o [N_OUP],
   output logic [N_OUP-1:0] oup_valid_o,
   input  logic [N_OUP-1:0] oup_ready_i,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] ptr_next;
   logic             lock_reg;
   logic             lock_next;
   logic [IDX_W-1:0] lock_idx_reg;
   logic [IDX_W-1:0] lock_idx_next;

   logic [5:0]       search;
   logic [IDX_W-1:0] search_idx;
   logic [IDX_W-1:0] target;
   logic             have_target;
   logic             offer;
   logic             hs;
   logic [N_OUP-1:0] sel;
   logic [N_OUP-1:0] slot_ready;

   assign search     = next_enabled(32'(en_i), 5'(ptr_reg), N_OUP);
   assign search_idx = IDX_W'(search[4:0]);

   // A locked target ignores en_i until its beat is accepted.
   assign target      = lock_reg ? lock_idx_reg : search_idx;
   assign have_target = lock_reg | search[5];

   // Outputs are forced idle while reset is asserted, even with inp_valid_i high.
   assign offer       = inp_valid_i & have_target & rst_ni;
   assign inp_ready_o = rst_ni & have_target & slot_ready[target];
   assign hs          = inp_valid_i & inp_ready_o;
   assign idx_o       = rst_ni ? target : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_reg      <= '0;
         lock_reg     <= 1'b0;
         lock_idx_reg <= '0;
      end else begin
         ptr_reg      <= ptr_next;
         lock_reg     <= lock_next;
         lock_idx_reg <= lock_idx_next;
      end
   end

   always_comb begin
      ptr_next      = ptr_reg;
      lock_next     = lock_reg;
      lock_idx_next = lock_idx_reg;
      if (hs) begin
         lock_next = 1'b0;
         ptr_next  = (target == IDX_W'(N_OUP - 1)) ? '0 : target + IDX_W'(1);
      end else if (offer) begin
         lock_next     = 1'b1;
         lock_idx_next = target;
      end
   end

   for (genvar gi = 0; gi < N_OUP; gi++) begin : g_out
      assign sel[gi] = (target == IDX_W'(gi));
`ifdef STREAM_DISTRIBUTOR_SPILL_EN
      logic slot_valid;

      stream_distributor_slot #(
         .DATA_T (DATA_T)
      ) u_slot (
         .clk       (clk_i),
         .rst_n     (rst_ni),
         .in_data   (inp_data_i),
         .in_valid  (offer & sel[gi]),
         .in_ready  (slot_ready[gi]),
         .out_data  (oup_data_o[gi]),
         .out_valid (slot_valid),
         .out_ready (oup_ready_i[gi])
      );

      assign oup_valid_o[gi] = slot_valid & rst_ni;
`else
      assign oup_valid_o[gi] = offer & sel[gi];
      assign oup_data_o[gi]  = inp_data_i;
      assign slot_ready[gi]  = oup_ready_i[gi];
`endif
   end

endmodule

// File: doc/stream_distributor.md
STREAM_DISTRIBUTOR -- requirements
Module: stream_distributor

Interface
REQ-001 SHALL have parameter DATA_T, default logic: payload type.
REQ-002 SHALL have parameter N_OUP, default 2: number of output streams, legal range 2..32.
REQ-003 SHALL have localparam IDX_W, default $clog2(N_OUP): target index width.
REQ-004 SHALL have port clk_i  in  1: single clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port en_i  in  N_OUP: per-output enable mask for rotation.
REQ-007 SHALL have port inp_data_i  in  DATA_T: input payload.
REQ-008 SHALL have port inp_valid_i  in  1: input valid.
REQ-009 SHALL have port inp_ready_o  out  1: input ready.
REQ-010 SHALL have port oup_data_o  out  N_OUP x DATA_T: output payloads.
REQ-011 SHALL have port oup_valid_o  out  N_OUP: output valids.
REQ-012 SHALL have port oup_ready_i  in  N_OUP: output readies.
REQ-013 SHALL have port idx_o  out  IDX_W: current target index, for debug.

Function
REQ-014 SHALL distribute input beats across enabled outputs in strict round-robin order, one beat per output per rotation.
REQ-015 SHALL compute the target as the first index at or after ptr, cyclically, where en_i is 1.
REQ-016 SHALL never make oup_valid_o depend on oup_ready_i.
REQ-017 SHALL lock the target while a beat is offered without a handshake; changes to en_i SHALL NOT move a locked target; the lock SHALL release on handshake.
REQ-018 SHALL set ptr to (target+1) mod N_OUP on each input handshake, wrapping N_OUP-1 to 0.
REQ-019 SHALL, when en_i is all-zero and no lock is held, drive inp_ready_o=0 and all oup_valid_o=0.
REQ-020 SHALL drive a locked target even if en_i[target] drops while locked; the next target SHALL skip that output.
REQ-021 SHALL, without the spill stage, be zero-latency: oup_valid_o[t]=inp_valid_i, inp_ready_o=oup_ready_i[t], oup_data_o[t]=inp_data_i; non-target valids SHALL be 0.
REQ-022 SHALL preserve beat order per output, and SHALL NOT drop or duplicate beats.

Reset
REQ-023 SHALL, during reset, set ptr=0, clear the lock, empty all spill slots, and drive all oup_valid_o=0 and idx_o=0.
REQ-024 SHALL reset immediately on rst_ni low, mid-transfer included; an in-flight beat is discarded.
REQ-025 SHALL, on the first cycle after reset release, target the first enabled output at or after index 0.

Configuration
REQ-026 SHALL, when macro STREAM_DISTRIBUTOR_SPILL_EN is defined, insert a 2-entry spill slot per output:
- latency 1 cycle;
- full throughput;
- inp_ready_o = target slot not full;
- no combinational path from oup_ready_i to inp_ready_o.
REQ-027 SHALL, when the macro is undefined, have no slots and the behaviour of REQ-021.

Structure
REQ-028 SHALL place in the shared common_cells package only the helper function for the next enabled index (cyclic priority search over the mask from a start index).
REQ-029 SHALL keep the per-output buffer in one sub-module, stream_distributor_slot: 2-entry spill, valid/ready on both sides, asynchronous active-low reset; it SHALL be instantiated only under the macro.

Verification
REQ-030 SHALL cover: N_OUP=4, en_i=4'b1111, 8 beats 0..7, all readies 1 -> output 0 gets 0,4; output 1 gets 1,5; output 2 gets 2,6; output 3 gets 3,7; idx_o sequence 0,1,2,3,0,...
REQ-031 SHALL cover: en_i=4'b1010, 4 beats -> outputs 1,3,1,3; outputs 0 and 2 never valid.
REQ-032 SHALL cover: beat offered to output 2 with oup_ready_i[2]=0; en_i[2] cleared for 5 cycles -> oup_valid_o[2] held, data stable, idx_o=2; on ready, handshake; next target 3.
REQ-033 SHALL cover: en_i=0 with no lock -> inp_ready_o=0 and all valids 0 for 10 cycles; setting en_i=4'b0100 -> first beat to output 2.
REQ-034 SHALL cover: with STREAM_DISTRIBUTOR_SPILL_EN, output 0 stalled, 6 beats in -> outputs 1..3 keep flowing; input stalls when slot 0 holds 2 beats; releasing output 0 drains 2 beats in order.
REQ-035 SHALL cover: rst_ni asserted mid-burst -> all valids 0 in the same cycle; after release, ptr=0 and slots empty.
